note_synth: RTL and testbench
=============================

Name: note_synth

Overview:
- Playback end of the guitar note path. Consumes the 32-bit note words produced by the string/fret capture and RAM path (play mode, one word per beat).
- Turns each word into up to six simultaneous square-wave voices, one per string.
- Mixes the voices into a signed PCM sample stream with a valid strobe, for the audio codec interface.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used only to build the half-period ROM.
- SAMPLE_DIV, 1042, clk cycles per output sample (about 48 kHz at 50 MHz).
- AMP, 4096, per-voice square-wave amplitude (positive magnitude).
- HOLD_SAMPLES, 24000, samples a voice sounds after a trigger.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- note_in  in  32  note word: bit 6*f+s = string s (0..5, 0 = low E) at fret f (0..4; 0 = open); bits 31:30 ignored
- note_valid  in  1  one-cycle strobe; note_in is sampled on this cycle
- enable  in  1  play-mode gate; 0 silences all voices
- sample_out  out  16  signed mixed sample
- sample_valid  out  1  one-cycle pulse when sample_out updates
- voice_active  out  6  per-string voice-on flags

Behaviour:
Reset and clocking:
- Reset is synchronous, active-low, on clk.
- Reset values: sample_out=0, sample_valid=0, voice_active=0, all voice counters, phases and hold counts 0.
- Sample divider returns to 0.

Sample timing:
- The divider counts 0..SAMPLE_DIV-1 and wraps.
- tick = (divider == SAMPLE_DIV-1).

Note decode:
- On note_valid with enable=1, for each string s: fret = highest f with bit 6*f+s set. This matches a guitar, where the higher fret shortens the string.
- If any bit is set for s, voice s is (re)triggered: state ON, phase counter 0, polarity high, hold count HOLD_SAMPLES, half-period from the ROM.
- If no bit is set for s, voice s is unaffected and keeps ringing.

Voice states:
- Each voice has two states, OFF and ON.
- ON: the phase counter increments every clk. On reaching half_period-1 it clears and polarity toggles.
- On each tick the hold count decrements. When a tick would take it from 1 to 0, the voice goes OFF at that tick.
- A retrigger on the same cycle as the expiry tick wins: the voice stays ON with a fresh hold count.

Half-period ROM (30 entries):
- Entry = round(CLK_HZ / (2*82.4069*2^(n/12))), where n = off[s]+f and off = {0,5,10,15,19,24} (standard tuning).
- Values at 50 MHz: E2 = 303373, A2 = 227273.
- Counters are 19 bits wide.

Mixing:
- On tick, sum over ON voices of (polarity ? +amp : -amp). OFF voices contribute 0.
- Maximum magnitude is 6*4096 = 24576, so no saturation is needed at default AMP. Other AMP values saturate to ±32767.
- sample_out and sample_valid are registered on the cycle after tick (latency 1 clk).
- sample_valid is high for exactly 1 clk per SAMPLE_DIV cycles.

enable=0:
- All voices are forced OFF on the next clk and note_valid is ignored.
- sample_valid keeps pulsing with sample_out=0.

Other boundary rules:
- note_valid with all-zero bits[29:0] is a no-op.
- Reset mid-note silences immediately.
- voice_active[s] = ON state of voice s, registered.

Optional Feature:
ENVELOPE_EN
- Defined: the voice amplitude is AMP >> q, where q = number of completed quarters of HOLD_SAMPLES since the trigger (0..3). A retrigger restores q=0.
- Undefined: the amplitude is constant AMP for the whole hold.

Test Plan:
- Reset: hold resetn=0 for 3 clk -> sample_out=0, sample_valid=0, voice_active=0; first sample_valid pulse appears SAMPLE_DIV clk after release, with value 0.
- Single E2: note_in=32'h1, enable=1 -> voice_active=6'b000001; first sample +4096; polarity flips every 303373 clk; sample values only +4096/-4096.
- Fret priority: note_in with bits 0 and 6 set -> voice 0 uses the fret-1 (F2) ROM entry, not open E2; voice_active=6'b000001.
- Full chord: all six open strings (note_in=32'h3F) -> first sample = +24576, voice_active=6'b111111.
- Hold expiry: HOLD_SAMPLES=4, trigger A2 (note_in=32'h2) -> 4 nonzero samples, then voice_active=0 and samples=0. Retrigger on the expiry tick keeps the voice ON.
- Gate: enable dropped mid-note -> next sample 0, voice_active=0. note_valid pulses while enable=0 have no effect.

Source files
------------

// File: rtl/note_synth.sv
// ---------------------------------------------------------------------------
// note_synth -- playback end of the guitar note path.
//
// Each accepted note word (re)triggers up to six square-wave voices, one per
// string. On every sample tick the ON voices are summed into a signed PCM
// sample that is presented one clock later with a one-cycle valid strobe.
//
// Ports:
//   clk           system clock
//   resetn        synchronous active-low reset
//   note_in       note word, bit 6*f+s = string s at fret f; bits 31:30 ignored
//   note_valid    one-cycle strobe qualifying note_in
//   enable        play-mode gate; 0 forces every voice OFF
//   sample_out    signed mixed sample, updated on the cycle after a tick
//   sample_valid  one-cycle pulse when sample_out updates
//   voice_active  per-string voice-on flags
//
// Optional build macro:
//   ENVELOPE_EN   voice amplitude steps down to AMP >> q, where q is the number
//                 of completed quarters of the hold time. Undefined: constant AMP.
// ---------------------------------------------------------------------------
module note_synth #(
   parameter int CLK_HZ       = 50000000,
   parameter int SAMPLE_DIV   = 1042,
   parameter int AMP          = 4096,
   parameter int HOLD_SAMPLES = 24000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [31:0]        note_in,
   input  logic               note_valid,
   input  logic               enable,
   output logic signed [15:0] sample_out,
   output logic               sample_valid,
   output logic [5:0]         voice_active
);

   localparam int NV     = 6;   // strings
   localparam int NF     = 5;   // frets 0..4
   localparam int PH_W   = 19;  // half-period / phase counter width
   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

   // Half-period table, entry (s*NF + f): clk cycles per half wave of the
   // note n = open-string offset + fret, relative to low E (82.4069 Hz).
   function automatic logic [NV*NF*PH_W-1:0] build_rom();
      logic [NV*NF*PH_W-1:0] rom;
      int                    base;
      real                   freq;
      rom = '0;
      for (int s = 0; s < NV; s++) begin
         case (s)
            0:       base = 0;
            1:       base = 5;
            2:       base = 10;
            3:       base = 15;
            4:       base = 19;
            default: base = 24;
         endcase
         for (int f = 0; f < NF; f++) begin
            freq = 82.4069 * (2.0 ** (real'(base + f) / 12.0));
            rom[(s*NF + f)*PH_W +: PH_W] =
               PH_W'($rtoi(real'(CLK_HZ) / (2.0 * freq) + 0.5));
         end
      end
      return rom;
   endfunction

   localparam logic [NV*NF*PH_W-1:0] HP_ROM = build_rom();

   typedef enum logic {V_OFF = 1'b0, V_ON = 1'b1} voice_state_t;

   // ---------------------------------------------------------------- divider
   logic [DIV_W-1:0] div_q;
   logic             tick;

   assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

   // NOTE: clocked state is always assigned with <= so every register samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (!resetn)   div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + DIV_W'(1);
   end

   // ----------------------------------------------------------- note decode
   // Highest set fret wins: ascending scan lets later (higher) frets overwrite.
   logic [NV-1:0] hit;
   logic [2:0]    fret [NV];
   logic          unused_bits;

   assign unused_bits = ^note_in[31:30];

   // NOTE: every output of a combinational block gets a default before any
   // condition, otherwise untaken paths would infer latches.
   always_comb begin
      for (int s = 0; s < NV; s++) begin
         hit[s]  = 1'b0;
         fret[s] = '0;
         for (int f = 0; f < NF; f++) begin
            if (note_in[6*f + s]) begin
               hit[s]  = 1'b1;
               fret[s] = 3'(f);
            end
         end
      end
   end

   // ---------------------------------------------------------------- voices
   voice_state_t      state_q [NV], state_d [NV];
   logic [PH_W-1:0]   phase_q [NV], phase_d [NV];
   logic [PH_W-1:0]   half_q  [NV], half_d  [NV];
   logic [HOLD_W-1:0] hold_q  [NV], hold_d  [NV];
   logic [NV-1:0]     pol_q, pol_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         // NOTE: these per-voice arrays are a handful of flops, not a RAM, so
         // they take the reset like any other register.
         for (int s = 0; s < NV; s++) begin
            state_q[s] <= V_OFF;
            phase_q[s] <= '0;
            half_q[s]  <= '0;
            hold_q[s]  <= '0;
         end
         pol_q <= '0;
      end else begin
         for (int s = 0; s < NV; s++) begin
            state_q[s] <= state_d[s];
            phase_q[s] <= phase_d[s];
            half_q[s]  <= half_d[s];
            hold_q[s]  <= hold_d[s];
         end
         pol_q <= pol_d;
      end
   end

   always_comb begin
      pol_d = pol_q;
      for (int s = 0; s < NV; s++) begin
         state_d[s] = state_q[s];
         phase_d[s] = phase_q[s];
         half_d[s]  = half_q[s];
         hold_d[s]  = hold_q[s];
         if (!enable) begin
            state_d[s] = V_OFF;
         end else if (note_valid && hit[s]) begin
            // Retrigger has priority over an expiry tick in the same cycle.
            state_d[s] = V_ON;
            phase_d[s] = '0;
            pol_d[s]   = 1'b1;
            hold_d[s]  = HOLD_W'(HOLD_SAMPLES);
            half_d[s]  = HP_ROM[(s*NF + int'(fret[s]))*PH_W +: PH_W];
         end else if (state_q[s] == V_ON) begin
            if (phase_q[s] == half_q[s] - PH_W'(1)) begin
               phase_d[s] = '0;
               pol_d[s]   = ~pol_q[s];
            end else begin
               phase_d[s] = phase_q[s] + PH_W'(1);
            end
            if (tick) begin
               hold_d[s] = hold_q[s] - HOLD_W'(1);
               if (hold_q[s] == HOLD_W'(1)) state_d[s] = V_OFF;
            end
         end
      end
   end

   // ------------------------------------------------------------------ mixer
`ifdef ENVELOPE_EN
   // Elapsed ticks are HOLD_SAMPLES - hold; compare 4*elapsed against whole
   // multiples of HOLD_SAMPLES so odd hold lengths need no divider.
   function automatic int voice_amp(input logic [HOLD_W-1:0] hold);
      int elapsed4;
      elapsed4 = 4 * (HOLD_SAMPLES - int'(hold));
      if (elapsed4 >= 3*HOLD_SAMPLES)      return AMP >> 3;
      else if (elapsed4 >= 2*HOLD_SAMPLES) return AMP >> 2;
      else if (elapsed4 >= HOLD_SAMPLES)   return AMP >> 1;
      else                                 return AMP;
   endfunction
`endif

   int                 mix_sum;
   logic signed [15:0] mix_sat;

   always_comb begin
      int amp;
      mix_sum = 0;
      for (int s = 0; s < NV; s++) begin
`ifdef ENVELOPE_EN
         amp = voice_amp(hold_q[s]);
`else
         amp = AMP;
`endif
         if (state_q[s] == V_ON) mix_sum += pol_q[s] ? amp : -amp;
      end
   end

   always_comb begin
      if (mix_sum > 32767)       mix_sat = 16'sd32767;
      else if (mix_sum < -32767) mix_sat = -16'sd32767;
      else                       mix_sat = 16'(mix_sum);
   end

   // Mix is taken from the voice state seen at the tick, registered one clk
   // later. voice_active follows the voice state register exactly.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sample_out   <= '0;
         sample_valid <= 1'b0;
         voice_active <= '0;
      end else begin
         sample_valid <= tick;
         if (tick) sample_out <= mix_sat;
         for (int s = 0; s < NV; s++) voice_active[s] <= (state_d[s] == V_ON);
      end
   end

endmodule

// File: tb/tb_note_synth.sv
// ---------------------------------------------------------------------------
// tb_note_synth -- self-checking bench for note_synth.
// Runs the DUT at a scaled-down clock so notes flip polarity and expire
// within a short run. A note-level reference model (time since trigger,
// ticks since trigger) predicts every output each cycle; a table of note
// words and hand-written sequences pin down the corner cases.
// ---------------------------------------------------------------------------
module tb_note_synth;

   localparam int CLK_HZ = 8000;
   localparam int SD     = 32;
   localparam int AMP    = 4096;
   localparam int HOLD   = 4;

   logic               clk = 1'b0;
   logic               resetn;
   logic [31:0]        note_in;
   logic               note_valid;
   logic               enable;
   logic signed [15:0] sample_out;
   logic               sample_valid;
   logic [5:0]         voice_active;

   note_synth #(
      .CLK_HZ(CLK_HZ), .SAMPLE_DIV(SD), .AMP(AMP), .HOLD_SAMPLES(HOLD)
   ) dut (
      .clk(clk), .resetn(resetn), .note_in(note_in), .note_valid(note_valid),
      .enable(enable), .sample_out(sample_out), .sample_valid(sample_valid),
      .voice_active(voice_active)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic signed [31:0] actual,
                        input logic signed [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   bit m_on    [6];
   int m_k     [6];   // clocks since trigger
   int m_hp    [6];   // half period in clocks
   int m_ticks [6];   // sample ticks since trigger
   int cyc;           // clocks since reset release
   int exp_sample;
   bit exp_valid;

   function automatic int rom_hp(input int s, input int f);
      int  off[6] = '{0, 5, 10, 15, 19, 24};
      real fr;
      fr = 82.4069 * (2.0 ** (real'(off[s] + f) / 12.0));
      return $rtoi(real'(CLK_HZ) / (2.0 * fr) + 0.5);
   endfunction

   function automatic int model_amp(input int s);
`ifdef ENVELOPE_EN
      int q;
      q = (m_ticks[s] * 4) / HOLD;
      if (q > 3) q = 3;
      return AMP >> q;
`else
      return AMP + 0*s;
`endif
   endfunction

   function automatic logic [5:0] active_vec();
      logic [5:0] v;
      for (int s = 0; s < 6; s++) v[s] = m_on[s];
      return v;
   endfunction

   task automatic model_edge(input bit nv, input bit en, input logic [31:0] note);
      bit tk;
      int sum;
      int f_hi;
      tk = (cyc % SD) == SD - 1;
      exp_valid = tk;
      if (tk) begin
         sum = 0;
         for (int s = 0; s < 6; s++)
            if (m_on[s])
               sum += (((m_k[s] / m_hp[s]) % 2) == 0) ? model_amp(s) : -model_amp(s);
         if (sum > 32767)  sum = 32767;
         if (sum < -32767) sum = -32767;
         exp_sample = sum;
      end
      for (int s = 0; s < 6; s++) begin
         f_hi = -1;
         for (int f = 0; f < 5; f++) if (note[6*f + s]) f_hi = f;
         if (!en) begin
            m_on[s] = 0;
         end else if (nv && f_hi >= 0) begin
            m_on[s] = 1; m_k[s] = 0; m_ticks[s] = 0; m_hp[s] = rom_hp(s, f_hi);
         end else if (m_on[s]) begin
            m_k[s]++;
            if (tk) begin
               m_ticks[s]++;
               if (m_ticks[s] == HOLD) m_on[s] = 0;
            end
         end
      end
      cyc++;
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic step(input bit nv, input bit en, input logic [31:0] note);
      note_valid = nv;
      enable     = en;
      note_in    = note;
      model_edge(nv, en, note);
      @(posedge clk);
      #1;
      check("sample_out", sample_out, exp_sample);
      check("sample_valid", {31'b0, sample_valid}, {31'b0, exp_valid});
      check("voice_active", {26'b0, voice_active}, {26'b0, active_vec()});
      note_valid = 1'b0;
   endtask

   task automatic do_reset();
      resetn     = 1'b0;
      note_valid = 1'b0;
      enable     = 1'b1;
      note_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_sample_out", sample_out, 0);
      check("reset_sample_valid", {31'b0, sample_valid}, 0);
      check("reset_voice_active", {26'b0, voice_active}, 0);
      cyc = 0; exp_sample = 0; exp_valid = 0;
      for (int s = 0; s < 6; s++) begin
         m_on[s] = 0; m_k[s] = 0; m_hp[s] = 1; m_ticks[s] = 0;
      end
      resetn = 1'b1;
   endtask

   task automatic advance_to(input int phase);
      while ((cyc % SD) != phase) step(1'b0, 1'b1, '0);
   endtask

   // ----------------------------------------------------------------- tests
   typedef struct {
      logic [31:0] note;
      logic [5:0]  act;
      int          first;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int first;
      int nonzero;
      bit seen;

      vecs[0] = '{32'h0000_0001, 6'b000001,  4096};  // open low E
      vecs[1] = '{32'h0000_0041, 6'b000001,  4096};  // E open + fret 1
      vecs[2] = '{32'h0000_003F, 6'b111111, 24576};  // open chord
      vecs[3] = '{32'h0000_0002, 6'b000010,  4096};  // open A
      vecs[4] = '{32'hC000_0000, 6'b000000,     0};  // ignored bits only
      vecs[5] = '{32'h0000_0000, 6'b000000,     0};  // empty word
      vecs[6] = '{32'h0000_0FC0, 6'b111111, 24576};  // all strings fret 1
      vecs[7] = '{32'h2000_0000, 6'b100000,  4096};  // high E fret 4

      // Reset values and first-pulse latency.
      do_reset();
      first = -1;
      for (int n = 1; n <= SD + 4; n++) begin
         step(1'b0, 1'b1, '0);
         if (sample_valid && first < 0) first = n;
      end
      check("first_pulse_latency", first, SD);

      // Table: trigger two clocks before a tick, check the first sample.
      foreach (vecs[i]) begin
         do_reset();
         advance_to(SD - 3);
         step(1'b1, 1'b1, vecs[i].note);
         step(1'b0, 1'b1, '0);
         step(1'b0, 1'b1, '0);
         check("vec_valid", {31'b0, sample_valid}, 1);
         check("vec_first_sample", sample_out, vecs[i].first);
         check("vec_voice_active", {26'b0, voice_active}, {26'b0, vecs[i].act});
      end

      // Fret priority: at 47 clocks after trigger F2 (46) has flipped, E2 (49) not.
      do_reset();
      advance_to(15);
      step(1'b1, 1'b1, 32'h0000_0041);
      repeat (48) step(1'b0, 1'b1, '0);
      check("fret_priority_sample", sample_out, -4096);
      check("fret_priority_active", {26'b0, voice_active}, 6'b000001);

      // Hold expiry: exactly HOLD nonzero samples, then silence.
      do_reset();
      advance_to(SD - 3);
      step(1'b1, 1'b1, 32'h0000_0002);
      nonzero = 0;
      for (int n = 0; n < 6*SD; n++) begin
         step(1'b0, 1'b1, '0);
         if (sample_valid && sample_out != 0) nonzero++;
      end
      check("hold_nonzero_samples", nonzero, HOLD);
      check("hold_expired_active", {26'b0, voice_active}, 0);
      check("hold_expired_sample", sample_out, 0);

      // Retrigger on the expiry tick keeps the voice ON.
      do_reset();
      advance_to(SD - 3);
      step(1'b1, 1'b1, 32'h0000_0002);
      repeat (2 + (HOLD-1)*SD - 1) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 32'h0000_0002);
      check("retrigger_on_expiry", {26'b0, voice_active}, 6'b000010);
      repeat (2*SD) step(1'b0, 1'b1, '0);
      check("retrigger_still_on", {26'b0, voice_active}, 6'b000010);

      // Gate: drop enable mid-note, pulse notes while disabled.
      do_reset();
      advance_to(SD - 3);
      step(1'b1, 1'b1, 32'h0000_003F);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      check("gate_active_off", {26'b0, voice_active}, 0);
      seen = 0;
      for (int n = 0; n < SD + 2 && !seen; n++) begin
         step(n % 3 == 0, 1'b0, 32'h0000_003F);
         check("gate_ignores_notes", {26'b0, voice_active}, 0);
         if (sample_valid) seen = 1;
      end
      check("gate_pulse_seen", {31'b0, seen}, 1);
      check("gate_sample_zero", sample_out, 0);

      // Reset mid-note silences at once.
      do_reset();
      advance_to(SD - 3);
      step(1'b1, 1'b1, 32'h0000_003F);
      repeat (5) step(1'b0, 1'b1, '0);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("reset_mid_note_active", {26'b0, voice_active}, 0);
      check("reset_mid_note_sample", sample_out, 0);

      // Randomised play against the model.
      do_reset();
      for (int n = 0; n < 6000; n++) begin
         logic [31:0] note;
         note = $urandom & $urandom;
         if ($urandom_range(0, 3) == 0) note = 32'(1) << $urandom_range(0, 31);
         step($urandom_range(0, 15) == 0, $urandom_range(0, 299) != 0, note);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
